// File: rtl/rmii_byte_assembler.sv
// RMII byte assembler: packs LSB-first dibits from the RMII receiver into bytes,
// delimits frames, counts bytes and flags misaligned / oversize frames.
// Optional FCS residue check is compiled in when ETH_CRC_CHECK_EN is defined;
// without it crc_ok is tied low and no CRC logic exists.
module rmii_byte_assembler #(
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned MAX_BYTES = 1522
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 axiiv,
   input  logic [1:0]           axiid,
   output logic                 axiov,
   output logic [7:0]           axiod,
   output logic                 frame_start,
   output logic                 frame_done,
   output logic [CNT_WIDTH-1:0] byte_count,
   output logic                 misaligned,
   output logic                 oversize,
   output logic                 crc_ok
);

   typedef enum logic [1:0] {
      StWaitIdle,
      StIdle,
      StCollect,
      StDone
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;

   state_e               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [5:0]           shreg_q, shreg_d;       // dibits 0..2 of the byte in flight
   logic                 axiov_q, axiov_d;
   logic [7:0]           axiod_q, axiod_d;
   logic                 frame_start_q, frame_start_d;
   logic                 frame_done_q, frame_done_d;
   logic [CNT_WIDTH-1:0] byte_count_q, byte_count_d;
   logic                 misaligned_q, misaligned_d;
   logic                 oversize_q, oversize_d;
   logic                 over_seen_q, over_seen_d; // internal, published at DONE
   logic                 take;
   logic [7:0]           new_byte;

`ifdef ETH_CRC_CHECK_EN
   localparam logic [31:0] CrcPoly    = 32'hEDB88320;
   localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

   logic [31:0] crc_q, crc_d;
   logic        crc_ok_q, crc_ok_d;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
      end
      return r;
   endfunction
`endif

   assign new_byte = {axiid, shreg_q};

   // Frame FSM, dibit packing, counters and status flags
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      shreg_d       = shreg_q;
      axiov_d       = 1'b0;
      axiod_d       = axiod_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      byte_count_d  = byte_count_q;
      misaligned_d  = misaligned_q;
      oversize_d    = oversize_q;
      over_seen_d   = over_seen_q;
      take          = 1'b0;
`ifdef ETH_CRC_CHECK_EN
      crc_d         = crc_q;
      crc_ok_d      = crc_ok_q;
`endif

      unique case (state_q)
         // A frame in flight at reset release is never joined mid-stream
         StWaitIdle: begin
            if (!axiiv) state_d = StIdle;
         end
         StIdle: begin
            if (axiiv) begin
               state_d      = StCollect;
               take         = 1'b1;
               byte_count_d = '0;
               misaligned_d = 1'b0;
               oversize_d   = 1'b0;
               over_seen_d  = 1'b0;
`ifdef ETH_CRC_CHECK_EN
               crc_d        = '1;
               crc_ok_d     = 1'b0;
`endif
            end
         end
         StCollect: begin
            if (axiiv) begin
               take = 1'b1;
            end else begin
               state_d      = StDone;
               frame_done_d = 1'b1;
               misaligned_d = (idx_q != 2'd0);
               oversize_d   = over_seen_q;
               idx_d        = 2'd0;   // partial byte is discarded
`ifdef ETH_CRC_CHECK_EN
               crc_ok_d     = (crc_q == CrcResidue) && (idx_q == 2'd0);
`endif
            end
         end
         // One cycle gap; any dibit presented here is ignored
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StWaitIdle;
         end
      endcase

      if (take) begin
         idx_d = idx_q + 2'd1;
         unique case (idx_q)
            2'd0: shreg_d[1:0] = axiid;
            2'd1: shreg_d[3:2] = axiid;
            2'd2: shreg_d[5:4] = axiid;
            default: begin
               // Byte index equals the count before increment
               if (32'(byte_count_q) >= MAX_BYTES) begin
                  over_seen_d = 1'b1;
               end else begin
                  axiov_d       = 1'b1;
                  axiod_d       = new_byte;
                  frame_start_d = (byte_count_q == '0);
               end
               if (byte_count_q != CntMax) byte_count_d = byte_count_q + 1'b1;
`ifdef ETH_CRC_CHECK_EN
               crc_d = crc_byte(crc_q, new_byte);
`endif
            end
         endcase
      end
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= StWaitIdle;
         idx_q         <= 2'd0;
         shreg_q       <= 6'd0;
         axiov_q       <= 1'b0;
         axiod_q       <= 8'h00;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         byte_count_q  <= '0;
         misaligned_q  <= 1'b0;
         oversize_q    <= 1'b0;
         over_seen_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         shreg_q       <= shreg_d;
         axiov_q       <= axiov_d;
         axiod_q       <= axiod_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         byte_count_q  <= byte_count_d;
         misaligned_q  <= misaligned_d;
         oversize_q    <= oversize_d;
         over_seen_q   <= over_seen_d;
      end
   end

`ifdef ETH_CRC_CHECK_EN
   // CRC accumulator and result flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         crc_q    <= '1;
         crc_ok_q <= 1'b0;
      end else begin
         crc_q    <= crc_d;
         crc_ok_q <= crc_ok_d;
      end
   end

   assign crc_ok = crc_ok_q;
`else
   assign crc_ok = 1'b0;
`endif

   assign axiov       = axiov_q;
   assign axiod       = axiod_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign byte_count  = byte_count_q;
   assign misaligned  = misaligned_q;
   assign oversize    = oversize_q;

endmodule
